// File: rtl/mips_run_monitor_pkg.sv
// Shared definitions for the MIPS run/dump monitor.
// State encodings and beat-type constants.
package mips_run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam logic BEAT_PC  = 1'b1;
  localparam logic BEAT_REG = 1'b0;

endpackage

// File: rtl/mips_run_monitor_if.sv
// Dump stream port of the run monitor.
// Master drives the beat, slave returns ready.
interface mips_run_monitor_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);

  logic              dump_valid;
  logic              dump_ready;
  logic              dump_is_pc;
  logic [IDX_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output dump_valid,
    output dump_is_pc,
    output dump_idx,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_is_pc,
    input  dump_idx,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Run/dump controller: gates the CPU, stops on halt PC or
// cycle timeout, then streams the PC and the register file.
module mips_run_monitor
  import mips_run_monitor_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int MAX_CYCLES = 4096,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PC_W-1:0]             halt_pc,
  input  logic [PC_W-1:0]             pc_in,
  output logic                        cpu_run_en,
  output logic [$clog2(NUM_REGS)-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]           rf_rd_data,
  mips_run_monitor_if.master          dump,
  output logic                        done,
  output logic                        timeout,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int IDX_W = $clog2(NUM_REGS);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              is_pc_q, is_pc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              to_q, to_d;

  logic halt_hit;
  logic to_hit;
  logic last;
  logic cnt_clr;
  logic run_en;

  assign halt_hit = (pc_in == halt_pc);
  assign to_hit   = (cycle_count == CNT_W'(MAX_CYCLES));
  assign last     = !is_pc_q &&
                    (idx_q == IDX_W'(NUM_REGS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    is_pc_d = is_pc_q;
    data_d  = data_q;
    to_d    = to_q;
    cnt_clr = 1'b0;
    run_en  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cnt_clr = 1'b1;
            to_d    = 1'b0;
            idx_d   = '0;
            is_pc_d = BEAT_PC;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          run_en = !halt_hit && !to_hit;
          // halt wins when both fire in the same cycle
          if (halt_hit) begin
            to_d    = 1'b0;
            state_d = ST_LOAD;
          end else if (to_hit) begin
            to_d    = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (is_pc_q) begin
            data_d = DATA_W'(pc_in);
          end else begin
            data_d = rf_rd_data;
          end
          state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (dump.dump_ready) begin
            if (last) begin
              state_d = ST_DONE;
            end else begin
              if (is_pc_q) begin
                is_pc_d = BEAT_REG;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
              state_d = ST_LOAD;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      is_pc_q <= 1'b0;
      data_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      is_pc_q <= is_pc_d;
      data_q  <= data_d;
      to_q    <= to_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (run_en),
    .count (cycle_count)
  );

  assign cpu_run_en      = run_en;
  assign rf_rd_addr      = idx_q;
  assign done            = (state_q == ST_DONE);
  assign timeout         = to_q;
  assign dump.dump_valid = (state_q == ST_PRESENT);
  assign dump.dump_is_pc = is_pc_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = last;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor.
// CPU model steps PC by 4 while cpu_run_en is high.
module tb_mips_run_monitor;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int NR = 32;
  localparam int IW = 5;
  localparam int MC = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [PW-1:0] halt_pc;
  logic [PW-1:0] pc;
  logic          cpu_run_en;
  logic [IW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  logic          pc_load;
  logic [PW-1:0] pc_init;
  logic          step_en;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] b_data [0:63];
  logic          b_pc   [0:63];
  logic [IW-1:0] b_idx  [0:63];
  logic          b_last [0:63];
  int            stall_err;

  always #5 clk = ~clk;

  mips_run_monitor_if #(.DATA_W(DW), .IDX_W(IW)) dif ();

  mips_run_monitor #(
    .PC_W       (PW),
    .DATA_W     (DW),
    .NUM_REGS   (NR),
    .MAX_CYCLES (MC),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .halt_pc     (halt_pc),
    .pc_in       (pc),
    .cpu_run_en  (cpu_run_en),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .dump        (dif),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always @(posedge clk) begin
    if (pc_load) pc <= pc_init;
    else if (cpu_run_en && step_en) pc <= pc + 32'd4;
  end

  function automatic logic [DW-1:0] rf_val(input int i);
    if (i == 0) return '0;
    return 32'hA500_0000 | DW'(i * 32'h0101);
  endfunction

  assign rf_rd_data = rf_val(int'(rf_rd_addr));

  task automatic set_pc(input logic [PW-1:0] v, input logic st);
    @(negedge clk);
    pc_init = v;
    pc_load = 1'b1;
    step_en = st;
    @(negedge clk);
    pc_load = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // records accepted beats; returns at the negedge after the last handshake
  task automatic collect(input int duty, input int max_b, output int n);
    logic          pv;
    logic          rdy;
    logic [DW-1:0] pd;
    logic [IW-1:0] pi;
    logic          pp;
    logic          pl;
    n = 0;
    pv = 1'b0;
    pd = '0;
    pi = '0;
    pp = 1'b0;
    pl = 1'b0;
    stall_err = 0;
    for (int cyc = 0; cyc < 3000 && n < max_b; cyc++) begin
      @(negedge clk);
      rdy = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      if (pv && dif.dump_valid) begin
        if (dif.dump_data !== pd || dif.dump_idx !== pi ||
            dif.dump_is_pc !== pp || dif.dump_last !== pl)
          stall_err++;
      end
      pd = dif.dump_data;
      pi = dif.dump_idx;
      pp = dif.dump_is_pc;
      pl = dif.dump_last;
      pv = dif.dump_valid && !rdy;
      dif.dump_ready = rdy;
      if (dif.dump_valid && rdy && n < 64) begin
        b_data[n] = dif.dump_data;
        b_pc[n]   = dif.dump_is_pc;
        b_idx[n]  = dif.dump_idx;
        b_last[n] = dif.dump_last;
        n++;
      end
    end
    @(negedge clk);
    dif.dump_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cpu_run_en, dif.dump_valid, done, timeout} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000",
               {cpu_run_en, dif.dump_valid, done, timeout});
    end
    total++;
    if ({cycle_count, dif.dump_data} !== '0) begin
      bad++;
      $display("FAIL reset_cnt got cnt=%0d data=%h want 0",
               cycle_count, dif.dump_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_halt();
    int n;
    logic [DW-1:0] ed;
    set_pc(32'h0, 1'b1);
    halt_pc = 32'h20;
    start_run();
    collect(100, 33, n);
    total++;
    if (n !== 33) begin
      bad++;
      $display("FAIL halt_beats got=%0d want=33", n);
    end
    total++;
    if ({dif.dump_valid, done} !== 2'b01) begin
      bad++;
      $display("FAIL halt_end got v/d=%b want 01",
               {dif.dump_valid, done});
    end
    total++;
    if (cycle_count !== 32'd8 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL halt_cnt got cnt=%0d to=%b want 8/0",
               cycle_count, timeout);
    end
    for (int k = 0; k < 33; k++) begin
      ed = (k == 0) ? 32'h20 : rf_val(k - 1);
      total++;
      if ({b_pc[k], b_idx[k], b_last[k], b_data[k]} !==
          {k == 0, IW'((k == 0) ? 0 : k - 1), k == 32, ed}) begin
        bad++;
        $display("FAIL halt_beat%0d got pc=%b i=%0d l=%b d=%h want d=%h",
                 k, b_pc[k], b_idx[k], b_last[k], b_data[k], ed);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    set_pc(32'h100, 1'b0);
    halt_pc = 32'h20;
    start_run();
    repeat (3) @(negedge clk);
    total++;
    if (cpu_run_en !== 1'b1 || cycle_count !== 32'd3) begin
      bad++;
      $display("FAIL to_midrun got en=%b cnt=%0d want 1/3",
               cpu_run_en, cycle_count);
    end
    collect(100, 33, n);
    total++;
    if (n !== 33 || done !== 1'b1) begin
      bad++;
      $display("FAIL to_beats got n=%0d done=%b want 33/1", n, done);
    end
    total++;
    if (cycle_count !== 32'd16 || timeout !== 1'b1 ||
        cpu_run_en !== 1'b0) begin
      bad++;
      $display("FAIL to_flags got cnt=%0d to=%b en=%b want 16/1/0",
               cycle_count, timeout, cpu_run_en);
    end
    total++;
    if (b_data[0] !== 32'h100) begin
      bad++;
      $display("FAIL to_pcbeat got=%h want=00000100", b_data[0]);
    end
  endtask

  task automatic test_stall();
    int n;
    int e;
    set_pc(32'h0, 1'b1);
    halt_pc = 32'h20;
    start_run();
    collect(30, 33, n);
    total++;
    if (n !== 33 || stall_err !== 0) begin
      bad++;
      $display("FAIL stall_stable got n=%0d errs=%0d want 33/0",
               n, stall_err);
    end
    e = 0;
    for (int k = 1; k < 33; k++)
      if (b_data[k] !== rf_val(k - 1) || b_idx[k] !== IW'(k - 1)) e++;
    total++;
    if (e !== 0 || b_data[0] !== 32'h20) begin
      bad++;
      $display("FAIL stall_order got errs=%0d pc=%h want 0/20",
               e, b_data[0]);
    end
    total++;
    if (b_data[1] !== 32'h0) begin
      bad++;
      $display("FAIL stall_r0 got=%h want=0", b_data[1]);
    end
  endtask

  task automatic test_priority();
    int n;
    set_pc(32'h0, 1'b1);
    halt_pc = 32'h40;
    start_run();
    collect(100, 33, n);
    total++;
    if (cycle_count !== 32'd16 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL prio got cnt=%0d to=%b want 16/0",
               cycle_count, timeout);
    end
    total++;
    if (n !== 33 || b_data[0] !== 32'h40) begin
      bad++;
      $display("FAIL prio_dump got n=%0d pc=%h want 33/40", n, b_data[0]);
    end
  endtask

  task automatic test_abort();
    int n;
    int e;
    set_pc(32'h0, 1'b1);
    halt_pc = 32'h20;
    start_run();
    collect(100, 5, n);
    @(negedge clk);
    total++;
    if (dif.dump_valid !== 1'b1 || dif.dump_idx !== 5'd4) begin
      bad++;
      $display("FAIL abort_pre got v=%b i=%0d want 1/4",
               dif.dump_valid, dif.dump_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if ({dif.dump_valid, done, cpu_run_en} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle got v/d/en=%b want 000",
               {dif.dump_valid, done, cpu_run_en});
    end
    set_pc(32'h0, 1'b1);
    start_run();
    collect(100, 33, n);
    e = 0;
    for (int k = 0; k < 33; k++)
      if (b_data[k] !== ((k == 0) ? 32'h20 : rf_val(k - 1))) e++;
    total++;
    if (n !== 33 || e !== 0 || cycle_count !== 32'd8 || done !== 1'b1) begin
      bad++;
      $display("FAIL abort_rerun got n=%0d errs=%0d cnt=%0d done=%b",
               n, e, cycle_count, done);
    end
  endtask

  task automatic test_rerun();
    int n;
    set_pc(32'h100, 1'b0);
    halt_pc = 32'h20;
    start_run();
    repeat (3) @(negedge clk);
    total++;
    if (cpu_run_en !== 1'b1 || cycle_count !== 32'd3) begin
      bad++;
      $display("FAIL rst_pre got en=%b cnt=%0d want 1/3",
               cpu_run_en, cycle_count);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({cpu_run_en, dif.dump_valid, done} !== 3'b000 ||
        cycle_count !== '0) begin
      bad++;
      $display("FAIL rst_async got en/v/d=%b cnt=%0d want 000/0",
               {cpu_run_en, dif.dump_valid, done}, cycle_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_pc(32'h100, 1'b0);
    start_run();
    repeat (5) @(negedge clk);
    start_run();
    total++;
    if (cycle_count !== 32'd7) begin
      bad++;
      $display("FAIL start_in_run got cnt=%0d want 7", cycle_count);
    end
    collect(100, 33, n);
    total++;
    if (n !== 33 || cycle_count !== 32'd16 || timeout !== 1'b1) begin
      bad++;
      $display("FAIL rerun_to got n=%0d cnt=%0d to=%b want 33/16/1",
               n, cycle_count, timeout);
    end
    set_pc(32'h0, 1'b1);
    start_run();
    total++;
    if (cycle_count !== '0 || timeout !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rerun_clr got cnt=%0d to=%b done=%b want 0/0/0",
               cycle_count, timeout, done);
    end
    collect(100, 33, n);
    total++;
    if (n !== 33 || cycle_count !== 32'd8 || done !== 1'b1) begin
      bad++;
      $display("FAIL rerun_halt got n=%0d cnt=%0d done=%b want 33/8/1",
               n, cycle_count, done);
    end
  endtask

  initial begin
    start = 1'b0;
    abort = 1'b0;
    halt_pc = '0;
    pc_load = 1'b0;
    pc_init = '0;
    step_en = 1'b0;
    pc = '0;
    dif.dump_ready = 1'b0;
    test_reset();
    test_halt();
    test_timeout();
    test_stall();
    test_priority();
    test_abort();
    test_rerun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
